// File: rtl/ramsim_pipe.sv
// Cycle-exact RAM endpoint: pipelined reads (RD_LAT) with bounded outstanding count,
// non-pipelined writes (WR_LAT). Optional byte-lane strobes with RAMSIM_WSTRB_EN.
module ramsim_pipe #(
  parameter int DATA_W  = 64,
  parameter int ADDR_W  = 64,
  parameter int DEPTH   = 1024,
  parameter int RD_LAT  = 4,
  parameter int WR_LAT  = 2,
  parameter int MAX_OUT = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rvalid,
  input  logic [ADDR_W-1:0]             raddr,
  input  logic                          wvalid,
  input  logic [ADDR_W-1:0]             waddr,
  input  logic [DATA_W-1:0]             wdata,
`ifdef RAMSIM_WSTRB_EN
  input  logic [DATA_W/8-1:0]           wstrb,
`endif
  output logic                          readReady,
  output logic                          writeReady,
  output logic                          readfin,
  output logic                          writefin,
  output logic [DATA_W-1:0]             rdata,
  output logic [$clog2(MAX_OUT+1)-1:0]  dbg_out_cnt,
  output logic                          dbg_wr_busy
);

  localparam int OFF_W = $clog2(DATA_W/8);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int OC_W  = $clog2(MAX_OUT+1);
  localparam int CNT_W = $clog2(WR_LAT+1);

  // Handshake: a request is accepted in a cycle where valid && ready are both high;
  // completions (readfin/writefin) are single-cycle pulses with no backpressure.

  typedef enum logic {IDLE, BUSY} wr_state_t;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [IDX_W-1:0]  ridx, widx;
  logic              rd_acc, wr_acc;
  logic [RD_LAT-1:0] vp;
  logic [DATA_W-1:0] dp [RD_LAT];
  logic [OC_W-1:0]   out_cnt;
  wr_state_t         wr_state;
  logic [CNT_W-1:0]  wcnt;
  logic              wfin;
  logic              unused_addr_bits;

  assign ridx = raddr[OFF_W +: IDX_W];
  assign widx = waddr[OFF_W +: IDX_W];
  assign unused_addr_bits = ^{raddr, waddr};

  assign readfin    = vp[RD_LAT-1];
  assign readReady  = !rst && ((out_cnt < OC_W'(MAX_OUT)) || readfin);
  assign writeReady = !rst && ((wr_state == IDLE) || wfin);
  assign writefin   = wfin;
  assign rd_acc     = rvalid && readReady;
  assign wr_acc     = wvalid && writeReady;
  assign rdata      = dp[RD_LAT-1];
  assign dbg_out_cnt = out_cnt;
  assign dbg_wr_busy = (wr_state == BUSY);

  // Array has no reset; reads in the pipeline block see the pre-write value.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
`ifdef RAMSIM_WSTRB_EN
      for (int b = 0; b < DATA_W/8; b++)
        if (wstrb[b]) mem[widx][b*8 +: 8] <= wdata[b*8 +: 8];
`else
      mem[widx] <= wdata;
`endif
    end
  end

  // Each data stage only moves when its input is valid, so the last stage holds rdata.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vp      <= '0;
      out_cnt <= '0;
      for (int i = 0; i < RD_LAT; i++) dp[i] <= '0;
    end else begin
      vp[0] <= rd_acc;
      if (rd_acc) dp[0] <= mem[ridx];
      for (int i = 1; i < RD_LAT; i++) begin
        vp[i] <= vp[i-1];
        if (vp[i-1]) dp[i] <= dp[i-1];
      end
      case ({rd_acc, readfin})
        2'b10:   out_cnt <= out_cnt + OC_W'(1);
        2'b01:   out_cnt <= out_cnt - OC_W'(1);
        default: out_cnt <= out_cnt;
      endcase
    end
  end

  // wfin is registered one cycle ahead so writefin rises exactly WR_LAT after accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_state <= IDLE;
      wcnt     <= '0;
      wfin     <= 1'b0;
    end else begin
      case (wr_state)
        IDLE: begin
          if (wvalid) begin
            wr_state <= BUSY;
            wcnt     <= CNT_W'(WR_LAT-1);
            wfin     <= (WR_LAT == 1);
          end
        end
        BUSY: begin
          if (!wfin) begin
            wcnt <= wcnt - CNT_W'(1);
            wfin <= (wcnt == CNT_W'(1));
          end else if (wvalid) begin
            wcnt <= CNT_W'(WR_LAT-1);
            wfin <= (WR_LAT == 1);
          end else begin
            wr_state <= IDLE;
            wfin     <= 1'b0;
          end
        end
        default: wr_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ramsim_pipe.sv
// Bench for ramsim_pipe: directed scenarios plus random traffic against a
// transaction-level model (memory array, due-cycle read queue, last-write cycle).
module tb_ramsim_pipe;
  localparam int DATA_W = 64, ADDR_W = 64, DEPTH = 1024;
  localparam int RD_LAT = 4, WR_LAT = 2, MAX_OUT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rvalid = 1'b0, wvalid = 1'b0;
  logic [ADDR_W-1:0] raddr = '0, waddr = '0;
  logic [DATA_W-1:0] wdata = '0;
  logic [7:0] wstrb = 8'hFF;
  logic readReady, writeReady, readfin, writefin;
  logic [DATA_W-1:0] rdata;
  logic [2:0] dbg_out_cnt;
  logic dbg_wr_busy;

  ramsim_pipe #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .RD_LAT(RD_LAT),
                .WR_LAT(WR_LAT), .MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .rst(rst), .rvalid(rvalid), .raddr(raddr), .wvalid(wvalid),
    .waddr(waddr), .wdata(wdata),
`ifdef RAMSIM_WSTRB_EN
    .wstrb(wstrb),
`endif
    .readReady(readReady), .writeReady(writeReady), .readfin(readfin),
    .writefin(writefin), .rdata(rdata), .dbg_out_cnt(dbg_out_cnt),
    .dbg_wr_busy(dbg_wr_busy));

  always #5 clk = ~clk;

  typedef struct { int due; logic [DATA_W-1:0] d; } rd_t;

  int checks = 0, errors = 0, cyc = 0;
  logic [DATA_W-1:0] mem_m [DEPTH];
  rd_t rdq[$];
  int last_w = -100;
  logic [DATA_W-1:0] last_rdata = '0;
  logic acc_r, acc_w, obs_fin, obs_wfin;
  logic [DATA_W-1:0] obs_data;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int widx(input logic [ADDR_W-1:0] a);
    return int'((a / (DATA_W/8)) % DEPTH);
  endfunction

  // One clock cycle: drive inputs, compare outputs with the model, advance the model.
  task automatic step(input logic r, input logic rv, input logic [63:0] ra,
                      input logic wv, input logic [63:0] wa, input logic [63:0] wd,
                      input logic [7:0] ws);
    logic fin_now, er, ew, ewf;
    logic [DATA_W-1:0] ed;
    int i;
    @(negedge clk);
    cyc++;
    rst = r; rvalid = rv; raddr = ra; wvalid = wv; waddr = wa; wdata = wd; wstrb = ws;
    #1;
    fin_now = (rdq.size() > 0) && (rdq[0].due == cyc);
    if (r) begin
      er = 0; ew = 0; ewf = 0; fin_now = 0; ed = '0;
    end else begin
      er  = (rdq.size() < MAX_OUT) || fin_now;
      ew  = (cyc >= last_w + WR_LAT);
      ewf = (cyc == last_w + WR_LAT);
      ed  = fin_now ? rdq[0].d : last_rdata;
    end
    chk("readReady", 64'(readReady), 64'(er));
    chk("writeReady", 64'(writeReady), 64'(ew));
    chk("readfin", 64'(readfin), 64'(fin_now));
    chk("writefin", 64'(writefin), 64'(ewf));
    chk("rdata", rdata, ed);
    chk("out_cnt", 64'(dbg_out_cnt), r ? 64'd0 : 64'(rdq.size()));
    obs_fin = readfin; obs_wfin = writefin; obs_data = rdata;
    acc_r = rv && er;
    acc_w = wv && ew;
    if (r) begin
      rdq.delete();
      last_w = -100;
      last_rdata = '0;
    end else begin
      if (fin_now) begin
        last_rdata = rdq[0].d;
        void'(rdq.pop_front());
      end
      if (acc_r) rdq.push_back('{due: cyc + RD_LAT, d: mem_m[widx(ra)]});
      if (acc_w) begin
        last_w = cyc;
        i = widx(wa);
`ifdef RAMSIM_WSTRB_EN
        for (int b = 0; b < DATA_W/8; b++)
          if (ws[b]) mem_m[i][b*8 +: 8] = wd[b*8 +: 8];
`else
        mem_m[i] = wd;
`endif
      end
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 8'h00);
  endtask

  task automatic do_write(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s);
    logic ok = 0;
    for (int k = 0; k < 10 && !ok; k++) begin
      step(0, 0, 0, 1, a, d, s);
      ok = acc_w;
    end
    chk("write_accept", 64'(ok), 64'd1);
  endtask

  task automatic do_read(input logic [63:0] a);
    logic ok = 0;
    for (int k = 0; k < 10 && !ok; k++) begin
      step(0, 1, a, 0, 0, 0, 8'h00);
      ok = acc_r;
    end
    chk("read_accept", 64'(ok), 64'd1);
  endtask

  task automatic wait_rd(output logic [DATA_W-1:0] d);
    logic got = 0;
    d = '0;
    for (int k = 0; k < 20 && !got; k++) begin
      idle(1);
      if (obs_fin) begin got = 1; d = obs_data; end
    end
    chk("readfin_timeout", 64'(got), 64'd1);
  endtask

  initial begin
    logic [DATA_W-1:0] d;
    int c0, nfin, maxcnt, n;
    logic [63:0] a;

    // Hold reset, then give every word used below a known value.
    for (int k = 0; k < 3; k++) step(1, 0, 0, 0, 0, 0, 8'h00);
    for (int k = 0; k < 32; k++) do_write(64'(k * 8), {$urandom, $urandom}, 8'hFF);
    idle(2);

    // Write then read 0x40: writefin WR_LAT after accept, readfin RD_LAT after accept.
    do_write(64'h40, 64'hDEADBEEF_CAFEF00D, 8'hFF);
    c0 = cyc;
    idle(1);
    do_read(64'h40);
    chk("writefin_cycle", 64'(cyc - c0), 64'(WR_LAT));
    chk("writefin_seen", 64'(obs_wfin), 64'd1);
    c0 = cyc;
    wait_rd(d);
    chk("read_latency", 64'(cyc - c0), 64'(RD_LAT));
    chk("read_0x40", d, 64'hDEADBEEF_CAFEF00D);

    // Read burst of 8 addresses, held valid until each is accepted.
    n = 0; nfin = 0; maxcnt = 0;
    for (int k = 0; k < 40 && (n < 8 || rdq.size() > 0); k++) begin
      if (n < 8) step(0, 1, 64'(n * 8), 0, 0, 0, 8'h00);
      else idle(1);
      if (acc_r && n < 8) n++;
      if (obs_fin) nfin++;
      if (int'(dbg_out_cnt) > maxcnt) maxcnt = int'(dbg_out_cnt);
    end
    chk("burst_accepts", 64'(n), 64'd8);
    chk("burst_fins", 64'(nfin), 64'd8);
    chk("burst_max_out", 64'(maxcnt), 64'(MAX_OUT));

    // Same-cycle read and write to one word: read sees the old value.
    do_write(64'h80, 64'h1111, 8'hFF);
    idle(2);
    step(0, 1, 64'h80, 1, 64'h80, 64'h2222, 8'hFF);
    chk("same_cycle_accept", 64'({acc_r, acc_w}), 64'b11);
    wait_rd(d);
    chk("same_cycle_old", d, 64'h1111);
    do_read(64'h80);
    wait_rd(d);
    chk("same_cycle_new", d, 64'h2222);

    // Upper address bits wrap onto the array.
    do_write(64'h8, 64'h01234567_89ABCDEF, 8'hFF);
    idle(1);
    do_read(64'(DEPTH * 8 + 8));
    wait_rd(d);
    chk("wrap_read", d, 64'h01234567_89ABCDEF);

    // Reset with three reads and one write in flight.
    do_write(64'h10, 64'h5555_AAAA_5555_AAAA, 8'hFF);
    do_read(64'h0); do_read(64'h18); do_read(64'h20);
    step(1, 0, 0, 0, 0, 0, 8'h00);
    nfin = 0;
    for (int k = 0; k < 8; k++) begin
      idle(1);
      if (k == 0) begin
        chk("post_rst_rready", 64'(readReady), 64'd1);
        chk("post_rst_wready", 64'(writeReady), 64'd1);
      end
      if (obs_fin || obs_wfin) nfin++;
    end
    chk("post_rst_no_fins", 64'(nfin), 64'd0);
    chk("post_rst_rdata", rdata, 64'd0);
    do_read(64'h40);
    wait_rd(d);
    chk("post_rst_read", d, 64'hDEADBEEF_CAFEF00D);
    do_read(64'h10);
    wait_rd(d);
    chk("post_rst_inflight_write", d, 64'h5555_AAAA_5555_AAAA);

`ifdef RAMSIM_WSTRB_EN
    do_write(64'hA0, 64'hFFFFFFFF_FFFFFFFF, 8'hFF);
    do_write(64'hA0, 64'h0, 8'h0F);
    do_write(64'hA0, 64'h12345678_12345678, 8'h00);
    idle(1);
    do_read(64'hA0);
    wait_rd(d);
    chk("wstrb_merge", d, 64'hFFFFFFFF_00000000);
`endif

    // Random traffic over the initialised words with wrapped high bits.
    for (int k = 0; k < 600; k++) begin
      a = 64'($urandom_range(0, 7)) * DEPTH * 8 + 64'($urandom_range(0, 31) * 8)
          + 64'($urandom_range(0, 7));
      step(($urandom_range(0, 99) == 0), 1'($urandom_range(0, 1)), a,
           1'($urandom_range(0, 1)),
           64'($urandom_range(0, 7)) * DEPTH * 8 + 64'($urandom_range(0, 31) * 8),
           {$urandom, $urandom}, 8'($urandom));
    end
    idle(RD_LAT + WR_LAT + 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/ramsim_pipe.md
# ramsim_pipe

Parametrised, synthesisable RAM simulation model with independent read and write channels, a fixed pipelined read latency, a fixed non-pipelined write latency, and a bounded number of outstanding reads. It replaces the DPI-backed RAM model as the memory endpoint behind the top-level simulation harness. Its cycle-exact, deterministic timing lets controllers be exercised under configurable memory latency and backpressure without host-side calls.

## Interface
- DATA_W, 64, data word width in bits; multiple of 8.
- ADDR_W, 64, byte-address width of raddr/waddr.
- DEPTH, 1024, number of DATA_W words; power of two.
- RD_LAT, 4, read latency in cycles, ≥1.
- WR_LAT, 2, write occupancy in cycles, ≥1.
- MAX_OUT, 4, maximum outstanding reads, 1..RD_LAT.

- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- rvalid  in  1  read request valid.
- raddr  in  ADDR_W  read byte address.
- wvalid  in  1  write request valid.
- waddr  in  ADDR_W  write byte address.
- wdata  in  DATA_W  write data.
- wstrb  in  DATA_W/8  byte-lane enables; present only with RAMSIM_WSTRB_EN.
- readReady  out  1  read request may be accepted this cycle.
- writeReady  out  1  write request may be accepted this cycle.
- readfin  out  1  one-cycle pulse: rdata valid.
- writefin  out  1  one-cycle pulse: write completed.
- rdata  out  DATA_W  read data.

## Operation
- Word index = (addr >> log2(DATA_W/8)) mod DEPTH. The low byte-offset bits are ignored. Upper bits wrap silently.
- Read accept: rvalid && readReady in cycle N. The array word is sampled at the end of cycle N and carried through an RD_LAT-deep valid/data shift pipeline. There is no response backpressure.
- Outstanding counter `out_cnt` (0..MAX_OUT):
  - increments on read accept;
  - decrements on readfin;
  - stays unchanged when both occur in the same cycle.
  - readReady = !rst && out_cnt < MAX_OUT, or out_cnt == MAX_OUT with readfin high in the same cycle.
- Write FSM, states IDLE and BUSY:
  - IDLE: writeReady = 1. On wvalid, the array is updated at the end of cycle N, the WR_LAT counter is loaded, and the FSM enters BUSY.
  - BUSY: writeReady = 0. The counter decrements each cycle. In the cycle it reaches its final count, writefin = 1, writeReady = 1, and a new write may be accepted in that same cycle (stay BUSY); otherwise go to IDLE.
- Read and write accepted in the same cycle to the same word: the read returns the old data. A write accepted in cycle N is visible to reads accepted from cycle N+1.
- Reset:
  - Clears the pipeline, out_cnt, the FSM (to IDLE), readfin, writefin, and rdata (to 0).
  - In-flight completions are dropped.
  - Array contents are not reset; they are X until written.
  - While rst is high, readReady = writeReady = 0.

## Timing
- Read accepted in cycle N: readfin = 1 and rdata valid in cycle N+RD_LAT.
- rdata holds its last value between readfin pulses.
- Write accepted in cycle N: writefin = 1 in cycle N+WR_LAT. writeReady = 0 in cycles N+1..N+WR_LAT-1.
- Sustained write throughput: 1 per WR_LAT cycles.
- Sustained read throughput: MAX_OUT per RD_LAT cycles; one per cycle when MAX_OUT = RD_LAT.
- Reset values: readReady = 0, writeReady = 0, readfin = 0, writefin = 0, rdata = 0. Both ready outputs rise in the first cycle after rst falls.

## Configuration
- RAMSIM_WSTRB_EN defined: the wstrb port exists, and only byte lanes with wstrb[i] = 1 are written. A write with all-zero wstrb still takes WR_LAT cycles and still pulses writefin.
- RAMSIM_WSTRB_EN undefined: there is no wstrb port, and every write updates the full word.

## Test plan
- Defaults. Write 0xDEADBEEF_CAFEF00D at waddr 0x40 in cycle 10, then read raddr 0x40 in cycle 12. Required: writefin in cycle 12, readfin in cycle 16, rdata = 0xDEADBEEF_CAFEF00D.
- Defaults. Hold rvalid for 8 cycles at addresses 0x0..0x38. Required:
  - readReady drops after 4 accepts, with out_cnt = 4;
  - accepts resume in the cycle of the first readfin;
  - 8 readfin pulses, data returned in order.
- Same-cycle read and write to 0x80 (old value 0x1111, new value 0x2222). Required: read returns 0x1111; a later read returns 0x2222.
- raddr = DEPTH*8 + 0x8. Required: returns the word at index 1 (wrap).
- Assert rst for 1 cycle while 3 reads and 1 write are in flight. Required:
  - no readfin/writefin afterwards;
  - rdata = 0;
  - both ready outputs = 1 in the following cycle;
  - previously written data still readable.
- RAMSIM_WSTRB_EN defined. Write 0xFFFF…FF, then write 0x0 with wstrb = 0x0F. Required: readback = 0xFFFFFFFF_00000000.
